// File: rtl/song_sequencer_pkg.sv
// Shared types and helpers for the song sequencer: FSM states, ROM entry layout, key encoders.
package music_pkg;
  localparam int PITCH_W  = 4;
  localparam int DUR_W    = 4;
  localparam int NUM_KEYS = 8;

  localparam logic [PITCH_W-1:0] PITCH_REST = '0;
  localparam logic [DUR_W-1:0]   DUR_END    = '0;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  typedef struct packed {
    logic [DUR_W-1:0]   dur;
    logic [PITCH_W-1:0] pitch;
  } note_t;

  localparam logic [NUM_KEYS-1:0] KEY_ONE = NUM_KEYS'(1);

  // Pitches beyond the keyboard (9..15) play as rests.
  function automatic logic [NUM_KEYS-1:0] pitch_onehot(input logic [PITCH_W-1:0] p);
    logic [NUM_KEYS-1:0] k;
    k = '0;
    if (p != PITCH_REST && p <= PITCH_W'(NUM_KEYS)) k = KEY_ONE << (p - PITCH_W'(1));
    return k;
  endfunction

  function automatic logic [NUM_KEYS-1:0] lowest_bit(input logic [NUM_KEYS-1:0] m);
    return m & (~m + KEY_ONE);
  endfunction
endpackage

// File: rtl/song_sequencer_if.sv
// Key bus between the player controls, the sequencer and the tone generator.
interface song_sequencer_if #(parameter int IDX_W = 6);
  import music_pkg::*;
  logic                start;
  logic                stop;
  logic [NUM_KEYS-1:0] manual_key;
  logic [NUM_KEYS-1:0] key;
  logic                busy;
  logic [IDX_W-1:0]    note_idx;

  modport master (output start, stop, manual_key, input key, busy, note_idx);
  modport slave  (input start, stop, manual_key, output key, busy, note_idx);
endinterface

// File: rtl/song_sequencer_rom.sv
// Fixed song table, {dur,pitch} per entry; anything not listed is the end marker.
module song_rom
  import music_pkg::*;
(
  input  logic [7:0] addr,
  output note_t      entry
);
  always_comb begin
    entry = '{dur: DUR_END, pitch: PITCH_REST};
    case (addr)
      8'd0, 8'd1:   entry = '{dur: 4'd1, pitch: 4'd1};
      8'd2, 8'd3:   entry = '{dur: 4'd1, pitch: 4'd5};
      8'd4, 8'd5:   entry = '{dur: 4'd1, pitch: 4'd6};
      8'd6:         entry = '{dur: 4'd2, pitch: 4'd5};
      8'd7, 8'd8:   entry = '{dur: 4'd1, pitch: 4'd4};
      8'd9, 8'd10:  entry = '{dur: 4'd1, pitch: 4'd3};
      8'd11, 8'd12: entry = '{dur: 4'd1, pitch: 4'd2};
      8'd13:        entry = '{dur: 4'd1, pitch: PITCH_REST};
      8'd14:        entry = '{dur: 4'd2, pitch: 4'd1};
      default:      entry = '{dur: DUR_END, pitch: PITCH_REST};
    endcase
  end
endmodule

// File: rtl/song_sequencer.sv
// Auto-play front end for the tone generator: manual one-hot passthrough or timed ROM playback.
// Define SONG_LOOP_EN to replay the song continuously until stop.
module song_sequencer
  import music_pkg::*;
#(
  parameter int BEAT_DIV = 12_500_000,
  parameter int GAP_CYC  = 500_000,
  parameter int SONG_LEN = 32
) (
  input  logic              clk,
  input  logic              clr,
  song_sequencer_if.slave   bus
);
  localparam int IDX_W = $clog2(SONG_LEN + 1);
  localparam int BW    = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t              state_q, state_n;
  logic [NUM_KEYS-1:0] key_q, key_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [DUR_W-1:0]    dur_q, dur_n, durc_q, durc_n;
  logic [BW-1:0]       beat_q, beat_n;
  logic [GW-1:0]       gap_q, gap_n;
  logic                busy_q;
  note_t               rom_entry;

  song_rom u_rom (.addr(8'(idx_q)), .entry(rom_entry));

  always_comb begin
    state_n = state_q;
    key_n   = key_q;
    idx_n   = idx_q;
    dur_n   = dur_q;
    durc_n  = durc_q;
    beat_n  = beat_q;
    gap_n   = gap_q;
    case (state_q)
      IDLE: begin
        key_n = lowest_bit(bus.manual_key);
        if (bus.start && !bus.stop) begin
          state_n = LOAD;
          idx_n   = '0;
          key_n   = '0;
        end
      end
      LOAD: begin
        key_n = '0;
        if (idx_q == IDX_W'(SONG_LEN) || rom_entry.dur == DUR_END) begin
          idx_n = '0;
`ifdef SONG_LOOP_EN
          // An empty song would spin in LOAD forever, so drop back to idle instead.
          state_n = (idx_q == '0) ? IDLE : LOAD;
`else
          state_n = IDLE;
`endif
        end else begin
          state_n = PLAY;
          key_n   = pitch_onehot(rom_entry.pitch);
          dur_n   = rom_entry.dur;
          durc_n  = '0;
          beat_n  = '0;
          gap_n   = '0;
        end
      end
      PLAY: begin
        beat_n = beat_q + BW'(1);
        if (beat_q == BW'(BEAT_DIV - 1)) begin
          beat_n = '0;
          durc_n = durc_q + DUR_W'(1);
          if (durc_q == dur_q - DUR_W'(1)) begin
            key_n  = '0;
            durc_n = '0;
            if (GAP_CYC == 0) begin
              state_n = LOAD;
              idx_n   = idx_q + IDX_W'(1);
            end else begin
              state_n = GAP;
              gap_n   = '0;
            end
          end
        end
      end
      GAP: begin
        gap_n = gap_q + GW'(1);
        if (gap_q == GW'(GAP_CYC - 1)) begin
          gap_n   = '0;
          idx_n   = idx_q + IDX_W'(1);
          state_n = LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_q != IDLE && bus.stop) begin
      state_n = IDLE;
      key_n   = '0;
      idx_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      dur_q   <= '0;
      durc_q  <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      key_q   <= key_n;
      idx_q   <= idx_n;
      dur_q   <= dur_n;
      durc_q  <= durc_n;
      beat_q  <= beat_n;
      gap_q   <= gap_n;
      busy_q  <= (state_n != IDLE);
    end
  end

  assign bus.key      = key_q;
  assign bus.busy     = busy_q;
  assign bus.note_idx = idx_q;
endmodule
